barrel_unshift: RTL



---
 rtl/barrel_unshift.sv | 89 ++++++++
 1 files changed

// File: rtl/barrel_unshift.sv
// Inverse-shift engine: restores the pre-shift word from a shifted/rotated word,
// one bit position per clock, using the upstream SC/AMT command encoding.
module barrel_unshift #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [width-1:0] DataIn,
  input  logic [1:0]       SC,
  input  logic [2:0]       AMT,
  output logic [width-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             lossy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [width-1:0] work;
  logic [width-1:0] work_step;
  logic [1:0]       sc_q;
  logic [2:0]       cnt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each step applies the opposite of the original one-bit shift.
  always_comb begin
    work_step = work;
    case (sc_q)
      2'b01:   work_step = {1'b0, work[width-1:1]};
      2'b10:   work_step = {work[width-2:0], 1'b0};
      2'b11:   work_step = {work[0], work[width-1:1]};
      default: work_step = work;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      work  <= '0;
      sc_q  <= '0;
      cnt   <= '0;
      R     <= '0;
      lossy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            work  <= DataIn;
            sc_q  <= SC;
            cnt   <= AMT;
            lossy <= ((SC == 2'b01) || (SC == 2'b10)) && (AMT != 3'd0);
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            work <= work_step;
            cnt  <= cnt - 3'd1;
          end else begin
            R <= work;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
